corefft_inplace: RTL and testbench

In-place, radix-2 decimation-in-time 32-point forward FFT for the GNSS test datapath. It loads one complex frame into an internal register-array buffer and computes the transform in that buffer with a single butterfly, using fixed 1/2 scaling per stage. It then streams the result in natural order under a consumer read handshake. A single buffer is used, so load, compute and unload are strictly sequential. The behavioural clock generator and edge-detector models used by the bench are outside this block.

---
 rtl/corefft_pkg.sv | 68 ++++++
 rtl/fft_butterfly.sv | 45 ++++
 rtl/corefft_inplace.sv | 164 ++++++++++++++++
 tb/tb_corefft_inplace.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/corefft_pkg.sv
// Shared constants, FSM state type and twiddle ROM builder for the 32-point in-place FFT.
package corefft_pkg;

    localparam int POINTS  = 32;
    localparam int LOGPTS  = 5;
    localparam int HALFPTS = 16;
    localparam int STEPS   = LOGPTS * HALFPTS;   // butterflies per frame
    localparam int TW_BITS = 18;                 // twiddle parts stored at the widest legal WIDTH

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_COMPUTE,
        ST_UNLOAD
    } fftState_e;

    // Entry k holds {re, im} of exp(-j*2*pi*k/32), each part sign-extended to TW_BITS.
    typedef logic [HALFPTS-1:0][2*TW_BITS-1:0] twRom_t;

    // Reverse the five address bits; input samples land in bit-reversed order.
    function automatic logic [LOGPTS-1:0] bitrev5(input logic [LOGPTS-1:0] v);
        return {v[0], v[1], v[2], v[3], v[4]};
    endfunction

    // cos(n*pi/16) scaled by 2^24 for n = 0..8; the rest of the circle follows by symmetry.
    function automatic int cosQ24(input int n);
        case (n)
            0:       return 16777216;
            1:       return 16454846;
            2:       return 15500126;
            3:       return 13949745;
            4:       return 11863283;
            5:       return 9320922;
            6:       return 6420363;
            7:       return 3273072;
            default: return 0;
        endcase
    endfunction

    // Round a non-negative 2^24-scaled magnitude to Q1.(width-1), saturating at 2^(width-1)-1.
    function automatic int quantizeQ(input int magQ24, input int width);
        int q;
        q = (magQ24 + (1 << (24 - width))) >>> (25 - width);
        if (q > (1 << (width - 1)) - 1) begin
            q = (1 << (width - 1)) - 1;
        end
        return q;
    endfunction

    // Build the 16-entry twiddle table for a given data width.
    function automatic twRom_t buildTwiddleRom(input int width);
        twRom_t rom;
        int     reV;
        int     imV;
        rom = '0;
        for (int k = 0; k < HALFPTS; k++) begin
            if (k <= 8) begin
                reV =  quantizeQ(cosQ24(k), width);
                imV = -quantizeQ(cosQ24(8 - k), width);
            end else begin
                reV = -quantizeQ(cosQ24(16 - k), width);
                imV = -quantizeQ(cosQ24(k - 8), width);
            end
            rom[k] = {TW_BITS'(reV), TW_BITS'(imV)};
        end
        return rom;
    endfunction

endpackage

// File: rtl/fft_butterfly.sv
// Combinational radix-2 DIT butterfly: t = B*W (rounded), X = (A+t)/2, Y = (A-t)/2 (floor).
module fft_butterfly #(
    parameter int WIDTH = 10
) (
    input  logic signed [WIDTH-1:0] aRe,
    input  logic signed [WIDTH-1:0] aIm,
    input  logic signed [WIDTH-1:0] bRe,
    input  logic signed [WIDTH-1:0] bIm,
    input  logic signed [WIDTH-1:0] wRe,
    input  logic signed [WIDTH-1:0] wIm,
    output logic signed [WIDTH-1:0] xRe,
    output logic signed [WIDTH-1:0] xIm,
    output logic signed [WIDTH-1:0] yRe,
    output logic signed [WIDTH-1:0] yIm
);

    localparam int PW = 2 * WIDTH + 1;
    localparam logic signed [PW-1:0] RND = PW'(2 ** (WIDTH - 2));

    logic signed [PW-1:0]  bReX, bImX, wReX, wImX;
    logic signed [PW-1:0]  prodRe, prodIm;
    logic signed [WIDTH:0] tRe, tIm;
    logic signed [WIDTH:0] sumRe, sumIm, difRe, difIm;

    // Complex multiply with round-half-up, then scaled add/subtract in WIDTH+1 bits.
    always_comb begin
        bReX   = PW'(bRe);
        bImX   = PW'(bIm);
        wReX   = PW'(wRe);
        wImX   = PW'(wIm);
        prodRe = bReX * wReX - bImX * wImX + RND;
        prodIm = bReX * wImX + bImX * wReX + RND;
        tRe    = (WIDTH+1)'(prodRe >>> (WIDTH - 1));
        tIm    = (WIDTH+1)'(prodIm >>> (WIDTH - 1));
        sumRe  = (WIDTH+1)'(aRe) + tRe;
        sumIm  = (WIDTH+1)'(aIm) + tIm;
        difRe  = (WIDTH+1)'(aRe) - tRe;
        difIm  = (WIDTH+1)'(aIm) - tIm;
        xRe    = WIDTH'(sumRe >>> 1);
        xIm    = WIDTH'(sumIm >>> 1);
        yRe    = WIDTH'(difRe >>> 1);
        yIm    = WIDTH'(difIm >>> 1);
    end

endmodule

// File: rtl/corefft_inplace.sv
// 32-point in-place radix-2 DIT FFT: bit-reversed load, 80 single-butterfly steps, natural-order unload.
module corefft_inplace
    import corefft_pkg::*;
#(
    parameter int WIDTH = 10
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic signed [WIDTH-1:0] DATAI_RE,
    input  logic signed [WIDTH-1:0] DATAI_IM,
    input  logic                    DATAI_VALID,
    output logic                    BUF_READY,
    output logic                    OUTP_READY,
    input  logic                    READ_OUTP,
    output logic signed [WIDTH-1:0] DATAO_RE,
    output logic signed [WIDTH-1:0] DATAO_IM,
    output logic                    DATAO_VALID,
    output logic                    PONG
);

    localparam twRom_t TW_ROM = buildTwiddleRom(WIDTH);

    fftState_e state, nextState;

    logic [LOGPTS-1:0] sampleCnt;
    logic [6:0]        stepCnt;
    logic [LOGPTS-1:0] readCnt;

    logic signed [WIDTH-1:0] bufRe [POINTS];
    logic signed [WIDTH-1:0] bufIm [POINTS];

    logic [2:0]        stage;
    logic [3:0]        bfly;
    logic [LOGPTS-1:0] span, low, idxA, idxB;
    logic [3:0]        twIdx;
    logic [2*TW_BITS-1:0]    twEntry;
    logic signed [WIDTH-1:0] wRe, wIm;
    logic signed [WIDTH-1:0] xRe, xIm, yRe, yIm;

    // State register.
    always_ff @(posedge CLK) begin
        // NOTE: state-holding blocks use non-blocking assignments so every register samples pre-edge values.
        if (RST) begin
            state <= ST_LOAD;
        end else begin
            state <= nextState;
        end
    end

    // Next-state decode and handshake flags.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        nextState  = state;
        BUF_READY  = 1'b0;
        OUTP_READY = 1'b0;
        case (state)
            ST_LOAD: begin
                BUF_READY = 1'b1;
                if (DATAI_VALID && sampleCnt == LOGPTS'(POINTS - 1)) begin
                    nextState = ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                if (stepCnt == 7'(STEPS - 1)) begin
                    nextState = ST_UNLOAD;
                end
            end
            ST_UNLOAD: begin
                OUTP_READY = 1'b1;
                if (READ_OUTP && readCnt == LOGPTS'(POINTS - 1)) begin
                    nextState = ST_LOAD;
                end
            end
            default: nextState = ST_LOAD;
        endcase
    end

    // Butterfly addressing: stage s pairs i and i+2^s, twiddle index (b mod 2^s) << (4-s).
    always_comb begin
        stage   = stepCnt[6:4];
        bfly    = stepCnt[3:0];
        span    = LOGPTS'(1) << stage;
        low     = {1'b0, bfly} & (span - LOGPTS'(1));
        idxA    = (({1'b0, bfly} - low) << 1) + low;
        idxB    = idxA + span;
        twIdx   = 4'(low << (3'd4 - stage));
        twEntry = TW_ROM[twIdx];
        wRe     = WIDTH'(twEntry[2*TW_BITS-1:TW_BITS]);
        wIm     = WIDTH'(twEntry[TW_BITS-1:0]);
    end

    fft_butterfly #(
        .WIDTH(WIDTH)
    ) u_butterfly (
        .aRe(bufRe[idxA]),
        .aIm(bufIm[idxA]),
        .bRe(bufRe[idxB]),
        .bIm(bufIm[idxB]),
        .wRe(wRe),
        .wIm(wIm),
        .xRe(xRe),
        .xIm(xIm),
        .yRe(yRe),
        .yIm(yIm)
    );

    // Frame buffer: bit-reversed sample writes during load, butterfly write-back during compute.
    always_ff @(posedge CLK) begin
        // NOTE: the buffer has no reset; every location is rewritten by the next load before it is read.
        case (state)
            ST_LOAD: begin
                if (DATAI_VALID) begin
                    bufRe[bitrev5(sampleCnt)] <= DATAI_RE;
                    bufIm[bitrev5(sampleCnt)] <= DATAI_IM;
                end
            end
            ST_COMPUTE: begin
                bufRe[idxA] <= xRe;
                bufIm[idxA] <= xIm;
                bufRe[idxB] <= yRe;
                bufIm[idxB] <= yIm;
            end
            default: ;
        endcase
    end

    // Counters, frame parity and the registered output port.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sampleCnt   <= '0;
            stepCnt     <= '0;
            readCnt     <= '0;
            PONG        <= 1'b0;
            DATAO_RE    <= '0;
            DATAO_IM    <= '0;
            DATAO_VALID <= 1'b0;
        end else begin
            DATAO_VALID <= 1'b0;
            case (state)
                ST_LOAD: begin
                    if (DATAI_VALID) begin
                        sampleCnt <= sampleCnt + LOGPTS'(1);
                        if (sampleCnt == LOGPTS'(POINTS - 1)) begin
                            PONG <= ~PONG;
                        end
                    end
                end
                ST_COMPUTE: begin
                    stepCnt <= (stepCnt == 7'(STEPS - 1)) ? 7'd0 : stepCnt + 7'd1;
                end
                ST_UNLOAD: begin
                    if (READ_OUTP) begin
                        DATAO_RE    <= bufRe[readCnt];
                        DATAO_IM    <= bufIm[readCnt];
                        DATAO_VALID <= 1'b1;
                        readCnt     <= readCnt + LOGPTS'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_corefft_inplace.sv
// Self-checking bench: directed and random frames compared against a floating-point DFT/32 model.
module tb_corefft_inplace;

    localparam int WIDTH = 10;
    localparam int N     = 32;
    localparam real PI   = 3.14159265358979323846;

    logic                    CLK;
    logic                    RST;
    logic signed [WIDTH-1:0] DATAI_RE;
    logic signed [WIDTH-1:0] DATAI_IM;
    logic                    DATAI_VALID;
    logic                    BUF_READY;
    logic                    OUTP_READY;
    logic                    READ_OUTP;
    logic signed [WIDTH-1:0] DATAO_RE;
    logic signed [WIDTH-1:0] DATAO_IM;
    logic                    DATAO_VALID;
    logic                    PONG;

    int vectors     = 0;
    int miscompares = 0;
    int inRe  [N];
    int inIm  [N];
    int expRe [N];
    int expIm [N];
    int pongExp;

    corefft_inplace #(
        .WIDTH(WIDTH)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .DATAI_RE   (DATAI_RE),
        .DATAI_IM   (DATAI_IM),
        .DATAI_VALID(DATAI_VALID),
        .BUF_READY  (BUF_READY),
        .OUTP_READY (OUTP_READY),
        .READ_OUTP  (READ_OUTP),
        .DATAO_RE   (DATAO_RE),
        .DATAO_IM   (DATAO_IM),
        .DATAO_VALID(DATAO_VALID),
        .PONG       (PONG)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input int observed, input int expected, input int tol = 0);
        int diff;
        vectors++;
        diff = observed - expected;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d (tol %0d) at %0t", tag, observed, expected, tol, $time);
        end
    endtask

    function automatic int roundReal(input real r);
        return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
    endfunction

    // Expected bins: exact DFT divided by 32, rounded to nearest.
    task automatic buildReference();
        real accRe, accIm, ang;
        for (int k = 0; k < N; k++) begin
            accRe = 0.0;
            accIm = 0.0;
            for (int n = 0; n < N; n++) begin
                ang = -2.0 * PI * real'((k * n) % N) / real'(N);
                accRe += real'(inRe[n]) * $cos(ang) - real'(inIm[n]) * $sin(ang);
                accIm += real'(inRe[n]) * $sin(ang) + real'(inIm[n]) * $cos(ang);
            end
            expRe[k] = roundReal(accRe / real'(N));
            expIm[k] = roundReal(accIm / real'(N));
        end
    endtask

    task automatic setImpulse();
        for (int n = 0; n < N; n++) begin
            inRe[n] = (n == 0) ? 256 : 0;
            inIm[n] = 0;
        end
    endtask

    task automatic setDc(input int v);
        for (int n = 0; n < N; n++) begin
            inRe[n] = v;
            inIm[n] = 0;
        end
    endtask

    task automatic setRandom();
        for (int n = 0; n < N; n++) begin
            inRe[n] = int'($urandom_range(0, 510)) - 255;
            inIm[n] = int'($urandom_range(0, 510)) - 255;
        end
    endtask

    task automatic loadFrame(input bit gap);
        int w;
        for (int n = 0; n < N; n++) begin
            if (gap && n > 0) begin
                DATAI_VALID = 1'b0;
                @(posedge CLK); #1;
            end
            w = 0;
            while (!BUF_READY && w < 300) begin
                @(posedge CLK); #1;
                w++;
            end
            if (!BUF_READY) check("load_wait", int'(BUF_READY), 1);
            DATAI_RE    = WIDTH'(inRe[n]);
            DATAI_IM    = WIDTH'(inIm[n]);
            DATAI_VALID = 1'b1;
            @(posedge CLK); #1;
        end
        DATAI_VALID = 1'b0;
        check("bufrdy_fall", int'(BUF_READY), 0);
        pongExp ^= 1;
    endtask

    task automatic awaitResult(input bit feed);
        int lat;
        lat = 0;
        while (!OUTP_READY && lat < 200) begin
            if (feed) begin
                DATAI_VALID = 1'b1;
                DATAI_RE    = WIDTH'($urandom_range(0, 1023));
                DATAI_IM    = WIDTH'($urandom_range(0, 1023));
            end
            @(posedge CLK); #1;
            lat++;
        end
        DATAI_VALID = 1'b0;
        check("latency", lat, 80);
        check("pong", int'(PONG), pongExp);
    endtask

    task automatic unloadFrame(input string name, input bit gap, input int tol);
        int  k;
        int  cyc;
        bit  rd;
        bit  ready;
        k   = 0;
        cyc = 0;
        while (k < N && cyc < 200) begin
            rd        = gap ? (cyc % 2 == 0) : 1'b1;
            READ_OUTP = rd;
            ready     = OUTP_READY;
            @(posedge CLK); #1;
            cyc++;
            if (rd && ready) begin
                check($sformatf("%s_vld%0d", name, k), int'(DATAO_VALID), 1);
                check($sformatf("%s_re%0d", name, k), int'(DATAO_RE), expRe[k], tol);
                check($sformatf("%s_im%0d", name, k), int'(DATAO_IM), expIm[k], tol);
                k++;
                if (k == N) begin
                    check($sformatf("%s_bufrdy_back", name), int'(BUF_READY), 1);
                    check($sformatf("%s_outrdy_fall", name), int'(OUTP_READY), 0);
                end
            end else begin
                check($sformatf("%s_gapvld", name), int'(DATAO_VALID), 0);
                if (k > 0) begin
                    check($sformatf("%s_hold_re", name), int'(DATAO_RE), expRe[k-1], tol);
                    check($sformatf("%s_hold_im", name), int'(DATAO_IM), expIm[k-1], tol);
                end
            end
        end
        check($sformatf("%s_count", name), k, N);
        // Reads past the last bin must not produce further pulses.
        READ_OUTP = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1;
            check($sformatf("%s_extra_vld", name), int'(DATAO_VALID), 0);
        end
        READ_OUTP = 1'b0;
    endtask

    task automatic runFrame(input string name, input bit gapIn, input bit gapOut, input bit feed, input int tol);
        buildReference();
        loadFrame(gapIn);
        awaitResult(feed);
        unloadFrame(name, gapOut, tol);
    endtask

    task automatic checkResetState(input string name);
        check($sformatf("%s_bufrdy", name), int'(BUF_READY), 1);
        check($sformatf("%s_outrdy", name), int'(OUTP_READY), 0);
        check($sformatf("%s_dvalid", name), int'(DATAO_VALID), 0);
        check($sformatf("%s_dre", name), int'(DATAO_RE), 0);
        check($sformatf("%s_dim", name), int'(DATAO_IM), 0);
        check($sformatf("%s_pong", name), int'(PONG), 0);
    endtask

    initial begin
        RST         = 1'b1;
        DATAI_RE    = '0;
        DATAI_IM    = '0;
        DATAI_VALID = 1'b0;
        READ_OUTP   = 1'b0;
        pongExp     = 0;
        repeat (2) @(posedge CLK);
        #1;
        checkResetState("rst");
        RST = 1'b0;

        setImpulse();
        runFrame("imp", 1'b0, 1'b0, 1'b1, 0);
        setDc(64);
        runFrame("dcp", 1'b0, 1'b0, 1'b0, 0);
        setDc(-64);
        runFrame("dcn", 1'b0, 1'b0, 1'b1, 0);
        for (int f = 0; f < 3; f++) begin
            setRandom();
            runFrame($sformatf("rnd%0d", f), f == 2, f == 1, f == 0, 4);
        end
        setImpulse();
        runFrame("impgap", 1'b1, 1'b1, 1'b0, 0);

        // Abort a frame part-way through the transform.
        setImpulse();
        loadFrame(1'b0);
        repeat (10) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        checkResetState("midrst");
        RST     = 1'b0;
        pongExp = 0;

        // Back-to-back alternating frames after the abort.
        for (int f = 0; f < 4; f++) begin
            if (f % 2 == 0) setImpulse();
            else            setDc(64);
            runFrame($sformatf("b2b%0d", f), 1'b0, 1'b0, 1'b0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
